// File: rtl/calendar_counter_pkg.sv
// Shared widths, limits and month-length constants for the calendar counter.
// Leap-year handling is enabled by defining LEAP_YEAR_EN.
package calendar_counter_pkg;

    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;
    localparam int YEAR_W  = 7;
    localparam int BCD_W   = 4;

    typedef logic [DAY_W-1:0]   day_t;
    typedef logic [MONTH_W-1:0] month_t;
    typedef logic [YEAR_W-1:0]  year_t;

    localparam month_t MONTH_MIN = 4'd1;
    localparam month_t MONTH_MAX = 4'd12;
    localparam year_t  YEAR_MIN  = 7'd0;
    localparam year_t  YEAR_MAX  = 7'd99;
    localparam day_t   DAY_MIN   = 5'd1;

    localparam day_t DAYS_28 = 5'd28;
    localparam day_t DAYS_29 = 5'd29;
    localparam day_t DAYS_30 = 5'd30;
    localparam day_t DAYS_31 = 5'd31;

endpackage

// File: rtl/calendar_counter_month_len.sv
// Combinational days-in-month lookup for a (month, year) pair.
// February gets 29 days in years divisible by 4 only when LEAP_YEAR_EN is defined.
module month_len
    import calendar_counter_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic [YEAR_W-1:0]  year,
    output logic [DAY_W-1:0]   len
);

    // Year only matters for February, and only in the leap-enabled build
    logic unused_year_s;
    assign unused_year_s = ^year;

    // Map month number to its length
    always_comb begin
        len = DAYS_31;
        case (month)
            4'd2: begin
`ifdef LEAP_YEAR_EN
                if (year[1:0] == 2'b00) begin
                    len = DAYS_29;
                end else begin
                    len = DAYS_28;
                end
`else
                len = DAYS_28;
`endif
            end
            4'd4, 4'd6, 4'd9, 4'd11: len = DAYS_30;
            default:                 len = DAYS_31;
        endcase
    end

endmodule

// File: rtl/calendar_counter.sv
// Day/month/year calendar with setup increments, BCD display digits and century pulse.
// Optional leap-year February controlled by the LEAP_YEAR_EN macro.
module calendar_counter
    import calendar_counter_pkg::*;
#(
    parameter int RST_DAY   = 1,
    parameter int RST_MONTH = 1,
    parameter int RST_YEAR  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               day_tick,
    input  logic               setup_day,
    input  logic               setup_month,
    input  logic               setup_year,
    output logic [DAY_W-1:0]   day,
    output logic [MONTH_W-1:0] month,
    output logic [YEAR_W-1:0]  year,
    output logic [BCD_W-1:0]   day_tens,
    output logic [BCD_W-1:0]   day_units,
    output logic [BCD_W-1:0]   month_tens,
    output logic [BCD_W-1:0]   month_units,
    output logic [BCD_W-1:0]   year_tens,
    output logic [BCD_W-1:0]   year_units,
    output logic               century_wrap
);

    day_t   day_r, day_nxt_s, len_s;
    month_t month_r, month_nxt_s, inc_month_s, len_month_s;
    year_t  year_r, year_nxt_s, inc_year_s, len_year_s;
    logic   wrap_r, wrap_nxt_s, edit_s;

    function automatic logic [7:0] to_bcd(input logic [6:0] bin);
        logic [6:0] tens_v;
        logic [6:0] units_v;
        tens_v  = bin / 7'd10;
        units_v = bin - (tens_v * 7'd10);
        return {tens_v[3:0], units_v[3:0]};
    endfunction

    assign inc_month_s = (month_r == MONTH_MAX) ? MONTH_MIN : month_r + 4'd1;
    assign inc_year_s  = (year_r == YEAR_MAX) ? YEAR_MIN : year_r + 7'd1;
    assign edit_s      = ~day_tick & (setup_year | setup_month);

    // One lookup serves both: edits need the length of the target month, ticks the current one
    always_comb begin
        len_month_s = month_r;
        len_year_s  = year_r;
        if (edit_s) begin
            if (setup_year) begin
                len_year_s = inc_year_s;
            end else begin
                len_month_s = inc_month_s;
            end
        end else begin
            len_month_s = month_r;
            len_year_s  = year_r;
        end
    end

    month_len u_month_len (
        .month (len_month_s),
        .year  (len_year_s),
        .len   (len_s)
    );

    // Next-state: day_tick beats all setups; among setups year > month > day
    always_comb begin
        day_nxt_s   = day_r;
        month_nxt_s = month_r;
        year_nxt_s  = year_r;
        wrap_nxt_s  = 1'b0;
        if (day_tick) begin
            if (day_r >= len_s) begin
                day_nxt_s = DAY_MIN;
                if (month_r == MONTH_MAX) begin
                    month_nxt_s = MONTH_MIN;
                    year_nxt_s  = inc_year_s;
                    wrap_nxt_s  = (year_r == YEAR_MAX);
                end else begin
                    month_nxt_s = inc_month_s;
                end
            end else begin
                day_nxt_s = day_r + 5'd1;
            end
        end else if (setup_year) begin
            year_nxt_s = inc_year_s;
            day_nxt_s  = (day_r > len_s) ? len_s : day_r;
        end else if (setup_month) begin
            month_nxt_s = inc_month_s;
            day_nxt_s   = (day_r > len_s) ? len_s : day_r;
        end else if (setup_day) begin
            day_nxt_s = (day_r >= len_s) ? DAY_MIN : day_r + 5'd1;
        end else begin
            day_nxt_s = day_r;
        end
    end

    // Calendar state and century pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            day_r   <= day_t'(RST_DAY);
            month_r <= month_t'(RST_MONTH);
            year_r  <= year_t'(RST_YEAR);
            wrap_r  <= 1'b0;
        end else begin
            day_r   <= day_nxt_s;
            month_r <= month_nxt_s;
            year_r  <= year_nxt_s;
            wrap_r  <= wrap_nxt_s;
        end
    end

    assign day          = day_r;
    assign month        = month_r;
    assign year         = year_r;
    assign century_wrap = wrap_r;

    assign {day_tens, day_units}     = to_bcd({2'b00, day_r});
    assign {month_tens, month_units} = to_bcd({3'b000, month_r});
    assign {year_tens, year_units}   = to_bcd(year_r);

endmodule

// File: tb/tb_calendar_counter.sv
// Directed and randomized bench for calendar_counter against a date-arithmetic model.
// Follows LEAP_YEAR_EN to pick the February rule.
module tb_calendar_counter;

`ifdef LEAP_YEAR_EN
    localparam bit LEAP_EN = 1'b1;
`else
    localparam bit LEAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, day_tick, setup_day, setup_month, setup_year;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic [3:0] day_tens, day_units, month_tens, month_units, year_tens, year_units;
    logic       century_wrap;

    int checks = 0;
    int errors = 0;
    int m_day, m_month, m_year, m_wrap;

    always #5 clk = ~clk;

    calendar_counter dut (
        .clk          (clk),
        .rst          (rst),
        .day_tick     (day_tick),
        .setup_day    (setup_day),
        .setup_month  (setup_month),
        .setup_year   (setup_year),
        .day          (day),
        .month        (month),
        .year         (year),
        .day_tens     (day_tens),
        .day_units    (day_units),
        .month_tens   (month_tens),
        .month_units  (month_units),
        .year_tens    (year_tens),
        .year_units   (year_units),
        .century_wrap (century_wrap)
    );

    function automatic int month_days(input int mo, input int yr);
        int tbl [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo == 2 && LEAP_EN && (yr % 4) == 0) return 29;
        return tbl[mo-1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".day"},   day,          m_day);
        check({tag, ".month"}, month,        m_month);
        check({tag, ".year"},  year,         m_year);
        check({tag, ".dt"},    day_tens,     m_day / 10);
        check({tag, ".du"},    day_units,    m_day % 10);
        check({tag, ".mt"},    month_tens,   m_month / 10);
        check({tag, ".mu"},    month_units,  m_month % 10);
        check({tag, ".yt"},    year_tens,    m_year / 10);
        check({tag, ".yu"},    year_units,   m_year % 10);
        check({tag, ".wrap"},  century_wrap, m_wrap);
    endtask

    task automatic model_reset();
        m_day = 1; m_month = 1; m_year = 0; m_wrap = 0;
    endtask

    task automatic model_update(input bit t, input bit sy, input bit sm, input bit sd);
        m_wrap = 0;
        if (t) begin
            if (m_day < month_days(m_month, m_year)) begin
                m_day++;
            end else begin
                m_day = 1;
                if (m_month == 12) begin
                    m_month = 1;
                    if (m_year == 99) m_wrap = 1;
                    m_year = (m_year + 1) % 100;
                end else begin
                    m_month++;
                end
            end
        end else if (sy) begin
            m_year = (m_year + 1) % 100;
            if (m_day > month_days(m_month, m_year)) m_day = month_days(m_month, m_year);
        end else if (sm) begin
            m_month = (m_month % 12) + 1;
            if (m_day > month_days(m_month, m_year)) m_day = month_days(m_month, m_year);
        end else if (sd) begin
            m_day = (m_day >= month_days(m_month, m_year)) ? 1 : m_day + 1;
        end
    endtask

    task automatic cycle_step(input bit t, input bit sy, input bit sm, input bit sd, input string tag);
        @(negedge clk);
        day_tick = t; setup_year = sy; setup_month = sm; setup_day = sd;
        @(posedge clk);
        model_update(t, sy, sm, sd);
        #1;
        day_tick = 1'b0; setup_year = 1'b0; setup_month = 1'b0; setup_day = 1'b0;
        check_all(tag);
    endtask

    task automatic set_date(input int d, input int mo, input int yr);
        for (int i = 0; i < 100 && m_year != yr; i++) cycle_step(1'b0, 1'b1, 1'b0, 1'b0, "set_y");
        for (int i = 0; i < 12 && m_month != mo; i++) cycle_step(1'b0, 1'b0, 1'b1, 1'b0, "set_m");
        for (int i = 0; i < 32 && m_day != d; i++) cycle_step(1'b0, 1'b0, 1'b0, 1'b1, "set_d");
        check("set.day", day, d);
        check("set.month", month, mo);
        check("set.year", year, yr);
    endtask

    initial begin
        rst = 1'b1; day_tick = 1'b0; setup_day = 1'b0; setup_month = 1'b0; setup_year = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        check("reset.day_const", day, 1);
        check("reset.month_const", month, 1);
        check("reset.year_const", year, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle_step(1'b0, 1'b0, 1'b0, 1'b0, "idle");

        set_date(30, 4, 24);
        cycle_step(1'b1, 1'b0, 1'b0, 1'b0, "apr30_tick");
        check("apr30.day", day, 1);
        check("apr30.month", month, 5);

        set_date(31, 1, 24);
        cycle_step(1'b1, 1'b0, 1'b0, 1'b0, "jan31_tick");
        check("jan31.day", day, 1);
        check("jan31.month", month, 2);

        set_date(28, 2, 24);
        cycle_step(1'b1, 1'b0, 1'b0, 1'b0, "feb28_24_tick");
        check("feb28_24.day", day, LEAP_EN ? 29 : 1);
        check("feb28_24.month", month, LEAP_EN ? 2 : 3);
        cycle_step(1'b1, 1'b0, 1'b0, 1'b0, "feb_leap_tick2");
        check("feb_leap2.day", day, LEAP_EN ? 1 : 2);
        check("feb_leap2.month", month, 3);

        set_date(28, 2, 23);
        cycle_step(1'b1, 1'b0, 1'b0, 1'b0, "feb28_23_tick");
        check("feb28_23.day", day, 1);
        check("feb28_23.month", month, 3);

        set_date(31, 12, 99);
        cycle_step(1'b1, 1'b0, 1'b0, 1'b0, "century_tick");
        check("century.wrap_hi", century_wrap, 1);
        check("century.year", year, 0);
        check("century.month", month, 1);
        cycle_step(1'b0, 1'b0, 1'b0, 1'b0, "century_after");
        check("century.wrap_lo", century_wrap, 0);

        set_date(1, 1, 99);
        cycle_step(1'b0, 1'b1, 1'b0, 1'b0, "setup_year_wrap");
        check("setup_year_wrap.year", year, 0);
        check("setup_year_wrap.wrap", century_wrap, 0);

        set_date(31, 3, 23);
        cycle_step(1'b0, 1'b0, 1'b1, 1'b0, "mar31_setup_month");
        check("mar31_clamp.day", day, 30);
        check("mar31_clamp.month", month, 4);

        set_date(28, 2, 24);
        cycle_step(1'b1, 1'b0, 1'b0, 1'b0, "leap_pre_tick");
        cycle_step(1'b0, 1'b1, 1'b0, 1'b0, "feb29_setup_year");
        check("feb29_clamp.day", day, LEAP_EN ? 28 : 1);
        check("feb29_clamp.month", month, LEAP_EN ? 2 : 3);
        check("feb29_clamp.year", year, 25);

        set_date(5, 6, 24);
        cycle_step(1'b1, 1'b0, 1'b0, 1'b1, "tick_vs_setup");
        check("tick_vs_setup.day", day, 6);
        check("tick_vs_setup.month", month, 6);
        set_date(5, 6, 24);
        cycle_step(1'b0, 1'b1, 1'b0, 1'b1, "year_vs_day");
        check("year_vs_day.day", day, 5);
        check("year_vs_day.year", year, 25);
        cycle_step(1'b0, 1'b0, 1'b1, 1'b1, "month_vs_day");
        check("month_vs_day.day", day, 5);
        check("month_vs_day.month", month, 7);

        for (int i = 0; i < 600; i++) begin
            cycle_step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, "random");
        end

        // Mid-cycle reset with a tick pending must win over the tick
        @(negedge clk);
        day_tick = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold_tick");
        @(negedge clk);
        rst = 1'b0;
        day_tick = 1'b0;
        #1;
        check_all("rst_release");
        cycle_step(1'b1, 1'b0, 1'b0, 1'b0, "post_rst_tick");
        check("post_rst.day", day, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
